// File: rtl/rv32i_pkg.sv
// Shared encodings for the rv32i core slice: arbiter FSM state and read-owner tags.
package rv32i_pkg;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_FETCH  = 2'd1,
    OWN_LOADER = 2'd2
  } rd_owner_e;

  localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/starve_counter.sv
// Saturating count of loader cycles spent waiting; flags when the loader must be forced in.
module starve_counter
  import rv32i_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic l_req_i,
  input  logic l_gnt_i,
  output logic forced_o
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT   = STARVE_CNT_W'(STARVE_LIMIT);
  localparam logic [STARVE_CNT_W-1:0] CNT_MAX = '1;

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (!l_req_i || l_gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses <= so all flops sample pre-edge values together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign forced_o = l_req_i && (cnt_q >= LIMIT);

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: loader owns the port during boot,
// fetch has priority at run time with a starvation escape for the loader.
module imem_arbiter
  import rv32i_pkg::*;
#(
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [31:0]       l_rdata,
  input  logic              boot_done,
  output logic              running,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  arb_state_e state_q;
  rd_owner_e  owner_q, owner_d;
  logic       forced;

  starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk_i   (CLK),
    .rst_i   (RST),
    .l_req_i (l_req),
    .l_gnt_i (l_gnt),
    .forced_o(forced)
  );

  // NOTE: reset clears only control state; there is no storage array here to reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_BOOT;
      running <= 1'b0;
    end else if (state_q == ST_BOOT && boot_done) begin
      state_q <= ST_RUN;
      running <= 1'b1;
    end
  end

  // Grants are gated by RST so the port is quiet for the whole reset pulse.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!RST) begin
      if (state_q == ST_BOOT) begin
        l_gnt = l_req;
      end else if (forced) begin
        l_gnt = 1'b1;
      end else begin
        f_gnt = f_req;
        l_gnt = l_req && !f_req;
      end
    end
  end

  always_comb begin
    mem_en    = f_gnt || l_gnt;
    mem_we    = l_gnt && l_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_gnt) begin
      mem_addr = f_addr[ADDR_W+1:2];
    end else if (l_gnt) begin
      mem_addr = l_addr[ADDR_W+1:2];
    end
    if (mem_en) begin
      mem_wdata = l_wdata;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (f_gnt) begin
      owner_d = OWN_FETCH;
    end else if (l_gnt && !l_we) begin
      owner_d = OWN_LOADER;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign f_rvalid = (owner_q == OWN_FETCH);
  assign l_rvalid = (owner_q == OWN_LOADER);
  assign f_rdata  = f_rvalid ? mem_rdata : '0;
  assign l_rdata  = l_rvalid ? mem_rdata : '0;

  // Address bits outside the word index are deliberately ignored (32 KiB wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{f_addr[1:0], f_addr[31:ADDR_W+2],
                              l_addr[1:0], l_addr[31:ADDR_W+2]};

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: vector table plus starvation and reset-mid-read sequences.
module tb_imem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        f_req, l_req, l_we, boot_done;
  logic [31:0] f_addr, l_addr, l_wdata;
  logic        f_gnt, f_rvalid, l_gnt, l_rvalid, running, mem_en, mem_we;
  logic [31:0] f_rdata, l_rdata, mem_wdata, mem_rdata;
  logic [12:0] mem_addr;

  logic [31:0] mem [0:8191];

  int n_pass = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  imem_arbiter #(.ADDR_W(13), .STARVE_LIMIT(8)) dut (
    .CLK(CLK), .RST(RST),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .boot_done(boot_done), .running(running),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous single-port RAM model: read data appears the cycle after the access.
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    logic        f_req;
    logic [31:0] f_addr;
    logic        l_req;
    logic        l_we;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        boot_done;
    logic        e_fg;
    logic        e_lg;
    logic        e_en;
    logic        e_we;
    logic [12:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_frv;
    logic        e_lrv;
    logic [31:0] e_frd;
    logic [31:0] e_lrd;
    logic        e_run;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic drive(input logic fr, input logic [31:0] fa, input logic lr, input logic lw,
                       input logic [31:0] la, input logic [31:0] ld, input logic bd);
    f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_addr = la; l_wdata = ld; boot_done = bd;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //            f_req f_addr        l_req l_we l_addr        l_wdata       bd  fg lg en we addr   wdata         frv lrv f_rdata       l_rdata       run
    vecs[0]  = '{1'b1, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_8000, 32'h0000_0013, 1'b0, 0, 1, 1, 1, 13'd0, 32'h0000_0013, 0, 0, 32'h0,         32'h0,         0};
    vecs[1]  = '{1'b1, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_8004, 32'h0010_0093, 1'b0, 0, 1, 1, 1, 13'd1, 32'h0010_0093, 0, 0, 32'h0,         32'h0,         0};
    vecs[2]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0, 0, 1, 1, 0, 13'd1, 32'h0,         0, 0, 32'h0,         32'h0,         0};
    vecs[3]  = '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 0, 0, 0, 0, 13'd0, 32'h0,         0, 1, 32'h0,         32'h0010_0093, 0};
    vecs[4]  = '{1'b1, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 1'b1, 0, 1, 1, 1, 13'd2, 32'hDEAD_BEEF, 0, 0, 32'h0,         32'h0,         0};
    vecs[5]  = '{1'b1, 32'h0000_8004, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1, 0, 1, 0, 13'd1, 32'h0,         0, 0, 32'h0,         32'h0,         1};
    vecs[6]  = '{1'b1, 32'h0000_000B, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, 0, 1, 0, 13'd2, 32'h0,         1, 0, 32'h0010_0093, 32'h0,         1};
    vecs[7]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'hFFFF_8000, 32'h0000_0000, 1'b0, 0, 1, 1, 0, 13'd0, 32'h0,         1, 0, 32'hDEAD_BEEF, 32'h0,         1};
    vecs[8]  = '{1'b1, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_0000, 1'b0, 1, 0, 1, 0, 13'd0, 32'h0,         0, 1, 32'h0,         32'h0000_0013, 1};
    vecs[9]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_000C, 32'h1234_5678, 1'b0, 0, 1, 1, 1, 13'd3, 32'h1234_5678, 1, 0, 32'h0000_0013, 32'h0,         1};
    vecs[10] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 0, 0, 0, 0, 13'd0, 32'h0,         0, 0, 32'h0,         32'h0,         1};

    // Reset state with both requesters active.
    RST = 1'b1;
    drive(1'b1, 32'h4, 1'b1, 1'b1, 32'h8, 32'h55, 1'b0);
    #2;
    check("rst_f_gnt", {31'd0, f_gnt}, 32'd0);
    check("rst_l_gnt", {31'd0, l_gnt}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_rvalid", {30'd0, f_rvalid, l_rvalid}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 11; i++) begin
      step();
      drive(vecs[i].f_req, vecs[i].f_addr, vecs[i].l_req, vecs[i].l_we,
            vecs[i].l_addr, vecs[i].l_wdata, vecs[i].boot_done);
      @(negedge CLK);
      check($sformatf("v%0d_f_gnt", i), {31'd0, f_gnt}, {31'd0, vecs[i].e_fg});
      check($sformatf("v%0d_l_gnt", i), {31'd0, l_gnt}, {31'd0, vecs[i].e_lg});
      check($sformatf("v%0d_mem_en", i), {31'd0, mem_en}, {31'd0, vecs[i].e_en});
      check($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].e_we});
      check($sformatf("v%0d_mem_addr", i), {19'd0, mem_addr}, {19'd0, vecs[i].e_addr});
      check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      check($sformatf("v%0d_f_rvalid", i), {31'd0, f_rvalid}, {31'd0, vecs[i].e_frv});
      check($sformatf("v%0d_l_rvalid", i), {31'd0, l_rvalid}, {31'd0, vecs[i].e_lrv});
      check($sformatf("v%0d_f_rdata", i), f_rdata, vecs[i].e_frd);
      check($sformatf("v%0d_l_rdata", i), l_rdata, vecs[i].e_lrd);
      check($sformatf("v%0d_running", i), {31'd0, running}, {31'd0, vecs[i].e_run});
    end

    // Starvation: fetch and loader read both held; loader forced in on cycle 9,
    // then the cleared counter makes it wait another 8 cycles (forced again on 18).
    for (int c = 1; c <= 19; c++) begin
      step();
      drive(1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_8000, 32'h0, 1'b0);
      @(negedge CLK);
      if (c == 9 || c == 18) begin
        check($sformatf("starve_c%0d_l_gnt", c), {31'd0, l_gnt}, 32'd1);
        check($sformatf("starve_c%0d_f_gnt", c), {31'd0, f_gnt}, 32'd0);
        check($sformatf("starve_c%0d_mem_addr", c), {19'd0, mem_addr}, 32'd0);
      end else begin
        check($sformatf("starve_c%0d_l_gnt", c), {31'd0, l_gnt}, 32'd0);
        check($sformatf("starve_c%0d_f_gnt", c), {31'd0, f_gnt}, 32'd1);
      end
      if (c == 10 || c == 19) begin
        check($sformatf("starve_c%0d_l_rvalid", c), {31'd0, l_rvalid}, 32'd1);
        check($sformatf("starve_c%0d_l_rdata", c), l_rdata, 32'h0000_0013);
        check($sformatf("starve_c%0d_f_rvalid", c), {31'd0, f_rvalid}, 32'd0);
      end
    end

    // Reset mid-read: fetch read granted, RST asserted right after the grant edge.
    step();
    drive(1'b1, 32'h0000_8004, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge CLK);
    check("rmr_f_gnt", {31'd0, f_gnt}, 32'd1);
    step();
    RST = 1'b1;
    #1;
    check("rmr_f_rvalid_in_rst", {31'd0, f_rvalid}, 32'd0);
    check("rmr_f_rdata_in_rst", f_rdata, 32'd0);
    check("rmr_f_gnt_in_rst", {31'd0, f_gnt}, 32'd0);
    check("rmr_mem_en_in_rst", {31'd0, mem_en}, 32'd0);
    check("rmr_running_in_rst", {31'd0, running}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    @(negedge CLK);
    check("rmr_f_rvalid_after", {31'd0, f_rvalid}, 32'd0);
    check("rmr_l_rvalid_after", {31'd0, l_rvalid}, 32'd0);
    check("rmr_running_after", {31'd0, running}, 32'd0);
    step();
    drive(1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge CLK);
    check("rmr_boot_f_gnt", {31'd0, f_gnt}, 32'd0);
    check("rmr_boot_mem_en", {31'd0, mem_en}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, giving the word-address width of the instruction memory port (8192 words).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, giving the loader wait-cycle count (1..15) that forces a loader grant.
REQ-003 SHALL have ports in this order:
- CLK  in  1  sole clock; all state updates on posedge.
- RST  in  1  reset, asynchronous, active-high.
- f_req  in  1  fetch read request.
- f_addr  in  32  fetch byte address.
- f_gnt  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  f_rdata valid.
- f_rdata  out  32  fetch read data.
- l_req  in  1  loader request.
- l_we  in  1  loader write (1) / read (0).
- l_addr  in  32  loader byte address.
- l_wdata  in  32  loader write data.
- l_gnt  out  1  loader request accepted this cycle.
- l_rvalid  out  1  l_rdata valid.
- l_rdata  out  32  loader read data.
- boot_done  in  1  one-cycle pulse ending the boot-load phase.
- running  out  1  high in RUN state.
- mem_en  out  1  memory port enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid the cycle after an mem_en && !mem_we access.

Function
REQ-004 SHALL implement FSM states BOOT and RUN; reset state BOOT; BOOT->RUN on boot_done=1; RUN has no exit except reset; boot_done in RUN ignored.
REQ-005 SHALL in BOOT hold f_gnt=0 and grant every l_req (l_gnt=l_req).
REQ-006 SHALL in RUN grant fetch whenever f_req=1, except on forced-loader cycles (REQ-008), when loader is granted and f_gnt=0.
REQ-007 SHALL in RUN grant the loader when l_req=1 and f_req=0.
REQ-008 SHALL keep a saturating 4-bit starvation counter: +1 each cycle l_req=1 && l_gnt=0; clear when l_gnt=1 or l_req=0; a cycle is forced-loader when counter >= STARVE_LIMIT and l_req=1.
REQ-009 SHALL make f_gnt/l_gnt combinational from current-cycle requests and state; at most one grant high per cycle.
REQ-010 SHALL drive mem_en = f_gnt|l_gnt, mem_we = l_gnt&l_we, mem_addr = granted address bits [ADDR_W+1:2], mem_wdata = l_wdata; mem outputs are don't-care-but-zero when mem_en=0.
REQ-011 SHALL ignore address bits [1:0] and bits above ADDR_W+1 (32 KiB wrap; byte 0x8000 maps to word 0).
REQ-012 SHALL register the read owner; exactly one cycle after a granted read, raise f_rvalid or l_rvalid for one cycle with that side's rdata = mem_rdata; writes produce no rvalid.
REQ-013 SHALL allow back-to-back grants every cycle (full throughput, one access per cycle).
REQ-014 SHALL, when boot_done and l_req coincide in BOOT, grant the loader that cycle and enter RUN next cycle.
REQ-015 SHALL drive running = (state==RUN).

Reset
REQ-016 SHALL on RST=1 asynchronously force: state BOOT, counter 0, read-owner cleared, f_rvalid=0, l_rvalid=0, f_rdata=0, l_rdata=0, running=0.
REQ-017 SHALL drop any read outstanding at reset assertion (no rvalid after release).
REQ-018 SHALL, while RST=1, hold f_gnt=l_gnt=mem_en=mem_we=0.

Structure
REQ-019 SHALL place the state encoding (BOOT, RUN) and the owner encoding (NONE, FETCH, LOADER) in the shared rv32i package; ADDR_W and STARVE_LIMIT remain module parameters.
REQ-020 SHALL be a single module; the starvation counter may be a sub-module named starve_counter.

Verification
REQ-021 Boot load: BOOT, l_req=1,l_we=1, addrs 0x8000/0x8004 data 0x00000013/0x00100093, f_req=1 -> l_gnt both cycles, f_gnt=0, mem_addr 0 then 1, no rvalid.
REQ-022 Boot exit: boot_done=1 with l_req=1 -> l_gnt that cycle; next cycle running=1 and f_req=1 gets f_gnt=1.
REQ-023 Fetch read: RUN, f_req=1 addr 0x8004, memory word1=0x00100093 -> f_rvalid=1, f_rdata=0x00100093 exactly one cycle later.
REQ-024 Starvation: RUN, STARVE_LIMIT=8, f_req and l_req (read, 0x8000) held high -> l_gnt=0 for 8 cycles, l_gnt=1 and f_gnt=0 on cycle 9, l_rvalid on cycle 10, counter 0 afterwards.
REQ-025 Reset mid-read: grant read, assert RST next cycle -> no rvalid, state BOOT, running=0, all outputs at reset values.
